// File: rtl/router_flit_buffer_if.sv
// Handshake bundle for router_flit_buffer: upstream flit input, downstream head output and occupancy.
// master = the side driving flits in and taking the head out; slave = the buffer itself.
interface router_flit_buffer_if #(
    parameter int DATA_W  = 4,
    parameter int COORD_W = 4,
    parameter int DEPTH   = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [COORD_W-1:0]       in_dest_x;
    logic [COORD_W-1:0]       in_dest_y;
    logic [DATA_W-1:0]        in_data;

    logic                     out_valid;
    logic                     out_ready;
    logic [COORD_W-1:0]       out_dest_x;
    logic [COORD_W-1:0]       out_dest_y;
    logic [DATA_W-1:0]        out_data;
    logic [COORD_W:0]         out_s_delta_x;
    logic [COORD_W:0]         out_s_delta_y;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_dest_x, in_dest_y, in_data, out_ready,
        input  in_ready, out_valid, out_dest_x, out_dest_y, out_data,
               out_s_delta_x, out_s_delta_y, count
    );

    modport slave (
        input  in_valid, in_dest_x, in_dest_y, in_data, out_ready,
        output in_ready, out_valid, out_dest_x, out_dest_y, out_data,
               out_s_delta_x, out_s_delta_y, count
    );
endinterface

// File: rtl/router_flit_buffer.sv
// Input-port flit FIFO for the mesh router; presents the head flit with signed deltas to this router.
// Optional same-cycle empty bypass is enabled by defining FLIT_BUF_BYPASS_EN.
module router_flit_buffer #(
    parameter int DATA_W  = 4,
    parameter int COORD_W = 4,
    parameter int DEPTH   = 4,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic               clk,
    input  logic               rst,
    router_flit_buffer_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [COORD_W-1:0] LX   = COORD_W'(LOCAL_X);
    localparam logic [COORD_W-1:0] LY   = COORD_W'(LOCAL_Y);
    localparam logic [CNT_W-1:0]   FULL = CNT_W'(DEPTH);

    typedef struct packed {
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
        logic [DATA_W-1:0]  data;
    } flit_t;

    flit_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    flit_t in_flit;
    flit_t head;
    logic  empty;
    logic  bypass;
    logic  push;
    logic  pop;
    logic  out_vld;

    assign in_flit = '{dest_x: bus.in_dest_x, dest_y: bus.in_dest_y, data: bus.in_data};
    assign empty   = (cnt == '0);

    // Ready is a pure function of occupancy so it never waits on the downstream pop.
    assign bus.in_ready = (cnt != FULL);

`ifdef FLIT_BUF_BYPASS_EN
    assign bypass = empty && bus.in_valid && bus.out_ready && !rst;
`else
    assign bypass = 1'b0;
`endif

    assign push    = bus.in_valid && bus.in_ready && !bypass;
    assign pop     = !empty && bus.out_ready;
    assign out_vld = !empty || bypass;

    always_comb begin
        head = '0;
        if (!empty)
            head = mem[rd_ptr];
        else if (bypass)
            head = in_flit;
    end

    assign bus.out_valid  = out_vld;
    assign bus.out_dest_x = head.dest_x;
    assign bus.out_dest_y = head.dest_y;
    assign bus.out_data   = head.data;
    assign bus.count      = cnt;

    // Deltas are gated too: an idle head of zero would otherwise show -LOCAL.
    assign bus.out_s_delta_x = out_vld ? ({1'b0, head.dest_x} - {1'b0, LX}) : '0;
    assign bus.out_s_delta_y = out_vld ? ({1'b0, head.dest_y} - {1'b0, LY}) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                cnt <= cnt + CNT_W'(1);
            else if (pop && !push)
                cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr] <= in_flit;
    end
endmodule
